// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sweep driver: FSM states, select width and signature fold.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        EMIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int SEL_W   = 4;
    localparam int NUM_OPS = 16;
    localparam int SIG_W   = 16;

    // Rotate-left by one, then xor in the zero-extended {carry, data} of the accepted beat.
    function automatic logic [SIG_W-1:0] sig_fold(input logic [SIG_W-1:0] sig,
                                                  input logic [SIG_W-1:0] beat);
        return {sig[SIG_W-2:0], sig[SIG_W-1]} ^ beat;
    endfunction

endpackage

// File: rtl/alu_seq_driver_if.sv
// Bundle between the sweep driver, the ALU under stimulus and the result stream consumer.
interface alu_seq_driver_if #(
    parameter int DATA_W = 2,
    parameter int OUT_W  = 8
);
    logic                       start;
    logic                       abort;
    logic [DATA_W-1:0]          alu_a;
    logic [DATA_W-1:0]          alu_b;
    logic [alu_pkg::SEL_W-1:0]  alu_sel;
    logic [OUT_W-1:0]           alu_out;
    logic                       alu_carry;
    logic                       res_valid;
    logic                       res_ready;
    logic [alu_pkg::SEL_W-1:0]  res_sel;
    logic [DATA_W-1:0]          res_a;
    logic [DATA_W-1:0]          res_b;
    logic [OUT_W-1:0]           res_data;
    logic                       res_carry;
    logic                       busy;
    logic                       done;
    logic [alu_pkg::SIG_W-1:0]  signature;

    modport master (
        input  start, abort, alu_out, alu_carry, res_ready,
        output alu_a, alu_b, alu_sel, res_valid, res_sel, res_a, res_b,
               res_data, res_carry, busy, done, signature
    );

    modport slave (
        output start, abort, alu_out, alu_carry, res_ready,
        input  alu_a, alu_b, alu_sel, res_valid, res_sel, res_a, res_b,
               res_data, res_carry, busy, done, signature
    );

endinterface

// File: rtl/alu_sweep_index.sv
// Operand/select sweep counter: b innermost, then a, then sel; wraps ripple naturally through one counter.
module alu_sweep_index
    import alu_pkg::*;
#(
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [SEL_W-1:0]  sel,
    output logic              last
);

    localparam int CNT_W = SEL_W + 2 * DATA_W;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign {sel, a, b} = cnt;
    assign last        = &cnt;

endmodule

// File: rtl/alu_seq_driver.sv
// Sweeps every (sel, a, b) into a combinational ALU, captures each result after SETTLE_CYC clocks
// and streams it out on valid/ready; res_ready low holds the beat and the ALU operands indefinitely.
module alu_seq_driver
    import alu_pkg::*;
#(
    parameter int DATA_W     = 2,
    parameter int OUT_W      = 8,
    parameter int SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    alu_seq_driver_if.master  bus
);

    localparam int             SC_W    = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam logic [SC_W-1:0] SC_INIT = SC_W'(SETTLE_CYC);

    state_t            state;
    state_t            state_nxt;
    logic [SC_W-1:0]   cnt;
    logic              cnt_zero;
    logic              hs;
    logic              last;
    logic              idx_clr;
    logic              idx_inc;
    logic              cnt_dec;
    logic              capture;
    logic              beat_acc;
    logic              abort_act;
    logic [DATA_W-1:0] idx_a;
    logic [DATA_W-1:0] idx_b;
    logic [SEL_W-1:0]  idx_sel;

    assign cnt_zero  = (cnt == '0);
    assign hs        = bus.res_valid & bus.res_ready;
    assign abort_act = bus.abort & (state != IDLE);

    alu_sweep_index #(.DATA_W(DATA_W)) u_index (
        .clk  (clk),
        .rst  (rst),
        .clr  (idx_clr),
        .inc  (idx_inc),
        .a    (idx_a),
        .b    (idx_b),
        .sel  (idx_sel),
        .last (last)
    );

    assign bus.alu_a   = idx_a;
    assign bus.alu_b   = idx_b;
    assign bus.alu_sel = idx_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SETTLE;
            SETTLE: begin
                if (bus.abort)     state_nxt = IDLE;
                else if (cnt_zero) state_nxt = EMIT;
            end
            EMIT: begin
                // Abort wins over a same-cycle handshake; that beat is dropped.
                if (bus.abort)     state_nxt = IDLE;
                else if (hs)       state_nxt = last ? DONE : SETTLE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        idx_clr  = 1'b0;
        idx_inc  = 1'b0;
        cnt_dec  = 1'b0;
        capture  = 1'b0;
        beat_acc = 1'b0;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            IDLE: idx_clr = bus.start;
            SETTLE: begin
                bus.busy = 1'b1;
                cnt_dec  = !bus.abort && !cnt_zero;
                capture  = !bus.abort && cnt_zero;
            end
            EMIT: begin
                bus.busy = 1'b1;
                beat_acc = !bus.abort && hs;
                idx_inc  = !bus.abort && hs && !last;
            end
            DONE:    bus.done = !bus.abort;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            bus.res_valid <= 1'b0;
            bus.res_sel   <= '0;
            bus.res_a     <= '0;
            bus.res_b     <= '0;
            bus.res_data  <= '0;
            bus.res_carry <= 1'b0;
            bus.signature <= '0;
        end else begin
            if (idx_clr) begin
                cnt           <= SC_INIT;
                bus.signature <= '0;
            end
            if (cnt_dec) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                bus.res_valid <= 1'b1;
                bus.res_sel   <= idx_sel;
                bus.res_a     <= idx_a;
                bus.res_b     <= idx_b;
                bus.res_data  <= bus.alu_out;
                bus.res_carry <= bus.alu_carry;
            end
            if (beat_acc) begin
                bus.res_valid <= 1'b0;
                bus.signature <= sig_fold(bus.signature, SIG_W'({bus.res_carry, bus.res_data}));
                cnt           <= SC_INIT;
            end
            if (abort_act) begin
                bus.res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_driver.sv
// Scoreboarded bench: ALU model out={sel,a,b}, carry=a[0]; extra instances cover SETTLE_CYC of 0 and 3.
`timescale 1ns/1ps
module tb_alu_seq_driver;
    import alu_pkg::*;

    localparam int DATA_W = 2;
    localparam int OUT_W  = 8;
    localparam int N      = 256;

    typedef struct packed {
        logic [3:0] sel;
        logic [1:0] a;
        logic [1:0] b;
        logic [7:0] data;
        logic       carry;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: beat k of the sweep and the signature after n accepted beats.
    function automatic beat_t ref_beat(input int k);
        beat_t r;
        r.sel   = 4'(k / 16);
        r.a     = 2'((k / 4) % 4);
        r.b     = 2'(k % 4);
        r.data  = 8'(r.sel * 16 + r.a * 4 + r.b);
        r.carry = r.a[0];
        return r;
    endfunction

    function automatic logic [15:0] ref_sig(input int n);
        logic [15:0] s;
        beat_t       r;
        s = 16'd0;
        for (int k = 0; k < n; k++) begin
            r = ref_beat(k);
            s = {s[14:0], s[15]} ^ {7'd0, r.carry, r.data};
        end
        return s;
    endfunction

    alu_seq_driver_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus();

    alu_seq_driver #(.DATA_W(DATA_W), .OUT_W(OUT_W), .SETTLE_CYC(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    assign bus.alu_out   = {bus.alu_sel, bus.alu_a, bus.alu_b};
    assign bus.alu_carry = bus.alu_a[0];

    logic start_aux = 1'b0;
    int   t_aux     = 0;
    bit   aux_fin [2];

    for (genvar g = 0; g < 2; g++) begin : g_aux
        localparam int SC = (g == 0) ? 0 : 3;
        alu_seq_driver_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) abus();
        alu_seq_driver #(.DATA_W(DATA_W), .OUT_W(OUT_W), .SETTLE_CYC(SC)) adut (
            .clk (clk),
            .rst (rst),
            .bus (abus.master)
        );
        assign abus.alu_out   = {abus.alu_sel, abus.alu_a, abus.alu_b};
        assign abus.alu_carry = abus.alu_a[0];
        assign abus.start     = start_aux;
        assign abus.abort     = 1'b0;
        assign abus.res_ready = 1'b1;

        int k   = 0;
        bit pv  = 1'b0;
        always @(negedge clk) begin
            if (!rst) begin
                if (abus.res_valid && !pv)
                    check("aux_valid_rise", cyc, t_aux + SC + 1 + k * (SC + 2));
                if (abus.res_valid) begin
                    check("aux_beat", {abus.res_sel, abus.res_a, abus.res_b, abus.res_data,
                                       abus.res_carry}, ref_beat(k));
                    k++;
                end
                if (abus.done) begin
                    check("aux_done_cycle", cyc, t_aux + N * (SC + 2));
                    check("aux_signature", abus.signature, ref_sig(N));
                    check("aux_beat_count", k, N);
                    aux_fin[g] = 1'b1;
                end
                pv = abus.res_valid;
            end
        end
    end

    // Scoreboard state shared between stimulus and monitor.
    beat_t exp_q[$];
    int    popped     = 0;
    int    base       = 0;
    int    done_cnt   = 0;
    int    t0         = 0;
    bit    chk_timing = 1'b0;
    int    rmode      = 0;
    int    rphase     = 0;

    always @(posedge clk) begin
        #1;
        rphase = (rphase + 1) % 3;
        case (rmode)
            0:       bus.res_ready = 1'b1;
            1:       bus.res_ready = (rphase == 0);
            default: bus.res_ready = 1'($urandom_range(0, 1));
        endcase
    end

    bit    prev_valid = 1'b0;
    bit    hold_vld   = 1'b0;
    beat_t hold;
    beat_t got;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            hold_vld   = 1'b0;
        end else begin
            got = {bus.res_sel, bus.res_a, bus.res_b, bus.res_data, bus.res_carry};
            if (bus.res_valid && !prev_valid && chk_timing)
                check("valid_rise_cycle", cyc, t0 + 2 + 3 * (popped - base));
            if (hold_vld && bus.res_valid)
                check("stall_stable", got, hold);
            hold_vld = 1'b0;
            if (bus.res_valid && !bus.res_ready) begin
                hold     = got;
                hold_vld = 1'b1;
            end
            if (bus.res_valid && bus.res_ready && !bus.abort) begin
                check("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("beat_data", got, exp_q.pop_front());
                popped++;
            end
            if (bus.done) begin
                done_cnt++;
                if (chk_timing) check("done_cycle", cyc, t0 + 3 * N);
            end
            prev_valid = bus.res_valid;
        end
    end

    task automatic reset_checks();
        check("rst_alu_idx", {bus.alu_a, bus.alu_b, bus.alu_sel}, 0);
        check("rst_res_beat", {bus.res_valid, bus.res_sel, bus.res_a, bus.res_b,
                               bus.res_data, bus.res_carry}, 0);
        check("rst_status", {bus.busy, bus.done, bus.signature}, 0);
    endtask

    task automatic start_sweep(input bit keep_high, input bit with_aux);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        if (with_aux) start_aux = 1'b1;
        @(posedge clk);
        #1;
        t0   = cyc;
        base = popped;
        if (with_aux) begin
            t_aux     = cyc;
            start_aux = 1'b0;
        end
        for (int k = 0; k < N; k++) exp_q.push_back(ref_beat(k));
        if (!keep_high) bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
        check("sweep_starts_at_zero", {bus.alu_sel, bus.alu_a, bus.alu_b}, 0);
    endtask

    task automatic wait_beats(input string name, input int n);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(posedge clk);
            #1;
            found = ((popped - base) >= n);
        end
        check(name, found, 1);
    endtask

    task automatic wait_done(input string name, input bit pulse_start);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = bus.done;
        end
        check(name, seen, 1);
        if (pulse_start) bus.start = 1'b1;
        check("sweep_signature", bus.signature, ref_sig(N));
        check("queue_drained", exp_q.size(), 0);
        check("beats_accepted", popped - base, N);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_after_done", bus.busy, 0);
    endtask

    initial begin
        int  dc;
        bit  found;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks();
        rst = 1'b0;

        // Full sweep with ready high, plus the SETTLE_CYC=0/3 instances in parallel.
        rmode      = 0;
        chk_timing = 1'b1;
        start_sweep(1'b0, 1'b1);
        wait_done("s1_done", 1'b0);
        chk_timing = 1'b0;

        // Abort while beat 10 is presented with ready high.
        start_sweep(1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk);
            #1;
            found = bus.res_valid && ((popped - base) == 10);
        end
        check("abort_reached_beat10", found, 1);
        dc        = done_cnt;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check("abort_valid_low", bus.res_valid, 0);
        check("abort_busy_low", bus.busy, 0);
        check("abort_signature", bus.signature, ref_sig(10));
        check("abort_beats", popped - base, 10);
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, dc);
        check("abort_stays_idle", bus.busy, 0);
        exp_q.delete();

        // Restart with start held high and random ready; pulse start in DONE.
        rmode = 2;
        start_sweep(1'b1, 1'b0);
        wait_beats("s5_reach_250", 250);
        bus.start = 1'b0;
        dc        = done_cnt;
        wait_done("s5_done", 1'b1);
        repeat (6) @(posedge clk);
        #1;
        check("no_restart_busy", bus.busy, 0);
        check("no_restart_valid", bus.res_valid, 0);
        check("one_done_pulse", done_cnt, dc + 1);
        check("idx_retained", {bus.alu_sel, bus.alu_a, bus.alu_b}, 8'hff);

        // Asynchronous reset in SETTLE of beat 100, checked before the next edge.
        rmode = 0;
        start_sweep(1'b0, 1'b0);
        wait_beats("s4_reach_100", 100);
        check("pre_reset_sel", bus.alu_sel, 6);
        check("pre_reset_signature", bus.signature, ref_sig(100));
        #2;
        rst = 1'b1;
        #1;
        reset_checks();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Backpressure: ready high one cycle in three.
        rmode = 1;
        start_sweep(1'b0, 1'b0);
        wait_done("s2_done", 1'b0);

        check("aux_settle0_finished", aux_fin[0], 1);
        check("aux_settle3_finished", aux_fin[1], 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected the bench to complete");
        $fatal(1, "watchdog expired");
    end

endmodule
